// File: rtl/alu32_issue_if.sv
// rtl/alu32_issue_if.sv - request, ALU and response bundle for the alu32 issue stage
interface alu32_issue_if;
  // request side
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_f;
  logic [3:0]  req_tag;
  // external ALU side
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_op_add;
  logic        alu_op_sub;
  logic        alu_op_and;
  logic        alu_op_or;
  logic        alu_op_xor;
  logic        alu_op_nor;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_overflow;
  // response side
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic        rsp_ov;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;
  logic [11:0] err_count;

  // issue stage view
  modport slave (
    input  req_valid, req_a, req_b, req_f, req_tag,
    output req_ready,
    output alu_a, alu_b, alu_op_add, alu_op_sub, alu_op_and, alu_op_or, alu_op_xor, alu_op_nor,
    input  alu_out, alu_zero, alu_overflow,
    output rsp_valid, rsp_out, rsp_zero, rsp_ov, rsp_tag, rsp_illegal, err_count,
    input  rsp_ready
  );

  // requester / ALU / consumer view
  modport master (
    output req_valid, req_a, req_b, req_f, req_tag,
    input  req_ready,
    input  alu_a, alu_b, alu_op_add, alu_op_sub, alu_op_and, alu_op_or, alu_op_xor, alu_op_nor,
    output alu_out, alu_zero, alu_overflow,
    input  rsp_valid, rsp_out, rsp_zero, rsp_ov, rsp_tag, rsp_illegal, err_count,
    output rsp_ready
  );
endinterface

// File: rtl/alu32_issue.sv
// rtl/alu32_issue.sv - 2-entry request FIFO feeding an external ALU with a registered response
module alu32_issue (
  input  logic         m_clock,
  input  logic         p_reset,
  alu32_issue_if.slave bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  occ_q, occ_d;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [31:0] a_q   [2];
  logic [31:0] b_q   [2];
  logic [5:0]  f_q   [2];
  logic [3:0]  tag_q [2];

  // held low through reset so req_ready rises only at the first edge afterwards
  logic        ready_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_out_q;
  logic        rsp_zero_q;
  logic        rsp_ov_q;
  logic [3:0]  rsp_tag_q;
  logic        rsp_illegal_q;
  logic [11:0] err_q;

  logic        req_ready;
  logic        push;
  logic        exec;
  logic [5:0]  head_f;
  logic        head_legal;
  logic        op_en;

  assign req_ready  = ready_q && (occ_q != FULL);
  assign push       = bus.req_valid && req_ready;
  assign exec       = (occ_q != EMPTY) && (!rsp_valid_q || bus.rsp_ready);
  assign head_f     = f_q[rd_ptr_q];
  // one-hot: non-zero with a single bit set
  assign head_legal = (head_f != 6'd0) && ((head_f & (head_f - 6'd1)) == 6'd0);
  assign op_en      = exec && head_legal;

  assign bus.req_ready   = req_ready;
  assign bus.alu_a       = exec ? a_q[rd_ptr_q] : 32'd0;
  assign bus.alu_b       = exec ? b_q[rd_ptr_q] : 32'd0;
  assign bus.alu_op_add  = op_en && head_f[5];
  assign bus.alu_op_sub  = op_en && head_f[4];
  assign bus.alu_op_and  = op_en && head_f[3];
  assign bus.alu_op_or   = op_en && head_f[2];
  assign bus.alu_op_xor  = op_en && head_f[1];
  assign bus.alu_op_nor  = op_en && head_f[0];
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_ov      = rsp_ov_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.err_count   = err_q;

  // occupancy follows push/pop; simultaneous push and pop leaves it unchanged
  always_comb begin
    occ_d = occ_q;
    if (push && !exec) begin
      occ_d = (occ_q == EMPTY) ? ONE : FULL;
    end else if (!push && exec) begin
      occ_d = (occ_q == FULL) ? ONE : EMPTY;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      occ_q    <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        a_q[i]   <= 32'd0;
        b_q[i]   <= 32'd0;
        f_q[i]   <= 6'd0;
        tag_q[i] <= 4'd0;
      end
    end else begin
      ready_q <= 1'b1;
      occ_q   <= occ_d;
      if (push) begin
        a_q[wr_ptr_q]   <= bus.req_a;
        b_q[wr_ptr_q]   <= bus.req_b;
        f_q[wr_ptr_q]   <= bus.req_f;
        tag_q[wr_ptr_q] <= bus.req_tag;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (exec) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // response register: load on exec, drop when consumed, hold under back-pressure
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_out_q     <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_ov_q      <= 1'b0;
      rsp_tag_q     <= 4'd0;
      rsp_illegal_q <= 1'b0;
      err_q         <= 12'd0;
    end else if (exec) begin
      rsp_valid_q   <= 1'b1;
      rsp_out_q     <= head_legal ? bus.alu_out : 32'd0;
      rsp_zero_q    <= head_legal && bus.alu_zero;
      rsp_ov_q      <= head_legal && bus.alu_overflow;
      rsp_tag_q     <= tag_q[rd_ptr_q];
      rsp_illegal_q <= !head_legal;
      if (!head_legal && (err_q != 12'hFFF)) begin
        err_q <= err_q + 12'd1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu32_issue.sv
// tb/tb_alu32_issue.sv - scoreboard bench for alu32_issue with a behavioural alu32
module tb_alu32_issue;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b010000;
  localparam logic [5:0] F_AND = 6'b001000;
  localparam logic [5:0] F_XOR = 6'b000010;

  logic m_clock;
  logic p_reset;
  int   checks = 0;
  int   errs   = 0;
  logic [38:0] sb [$];

  alu32_issue_if bus ();

  alu32_issue dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  // behavioural alu32 driven by the op strobes
  logic [31:0] alu_r;
  logic        alu_v;
  always_comb begin
    alu_r = 32'd0;
    alu_v = 1'b0;
    if (bus.alu_op_add) begin
      alu_r = bus.alu_a + bus.alu_b;
      alu_v = (bus.alu_a[31] == bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
    end else if (bus.alu_op_sub) begin
      alu_r = bus.alu_a - bus.alu_b;
      alu_v = (bus.alu_a[31] != bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
    end else if (bus.alu_op_and) alu_r = bus.alu_a & bus.alu_b;
    else if (bus.alu_op_or)  alu_r = bus.alu_a | bus.alu_b;
    else if (bus.alu_op_xor) alu_r = bus.alu_a ^ bus.alu_b;
    else if (bus.alu_op_nor) alu_r = ~(bus.alu_a | bus.alu_b);
  end
  assign bus.alu_out      = alu_r;
  assign bus.alu_zero     = (alu_r == 32'd0);
  assign bus.alu_overflow = alu_v;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // expected response {out, zero, ov, tag, illegal}
  function automatic logic [38:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic [3:0] tag);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (f)
      6'b100000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      6'b010000: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      6'b001000: r = a & b;
      6'b000100: r = a | b;
      6'b000010: r = a ^ b;
      6'b000001: r = ~(a | b);
      default:   return {32'd0, 1'b0, 1'b0, tag, 1'b1};
    endcase
    return {r, (r == 32'd0), v, tag, 1'b0};
  endfunction

  // response monitor: compare each consumed response with the scoreboard head
  always @(negedge m_clock) begin
    if (p_reset && bus.rsp_valid && bus.rsp_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("rsp", {25'd0, bus.rsp_out, bus.rsp_zero, bus.rsp_ov, bus.rsp_tag, bus.rsp_illegal},
            {25'd0, sb.pop_front()});
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                      input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    bus.req_a = a; bus.req_b = b; bus.req_f = f; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge m_clock);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge m_clock);
      #1;
      sb.push_back(exp_rsp(a, b, f, tag));
    end
    bus.req_valid = 1'b0;
    chk("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !bus.rsp_valid) break;
      @(posedge m_clock);
      #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [5:0] strobes();
    return {bus.alu_op_add, bus.alu_op_sub, bus.alu_op_and,
            bus.alu_op_or, bus.alu_op_xor, bus.alu_op_nor};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_f = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_strobes", 64'(strobes()), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    @(negedge m_clock);
    p_reset = 1'b1;
    #1;
    chk("ready_before_edge", 64'(bus.req_ready), 64'd0);
    @(posedge m_clock); #1;
    chk("ready_after_edge", 64'(bus.req_ready), 64'd1);

    // add 7 + 5, tag 3
    push(32'd7, 32'd5, F_ADD, 4'd3);
    chk("add_strobes", 64'(strobes()), 64'(F_ADD));
    chk("add_alu_a", 64'(bus.alu_a), 64'd7);
    chk("add_alu_b", 64'(bus.alu_b), 64'd5);
    @(posedge m_clock); #1;
    chk("add_valid", 64'(bus.rsp_valid), 64'd1);
    chk("add_out", 64'(bus.rsp_out), 64'd12);
    chk("add_tag", 64'(bus.rsp_tag), 64'd3);
    chk("add_strobe_off", 64'(strobes()), 64'd0);
    wait_drain();

    // signed overflow and zero
    push(32'h8000_0000, 32'd1, F_SUB, 4'd4);
    @(posedge m_clock); #1;
    chk("sub_ov_out", 64'(bus.rsp_out), 64'h7FFF_FFFF);
    chk("sub_ov_flag", 64'(bus.rsp_ov), 64'd1);
    push(32'd5, 32'd5, F_SUB, 4'd5);
    @(posedge m_clock); #1;
    chk("sub_zero_out", 64'(bus.rsp_out), 64'd0);
    chk("sub_zero_flag", 64'(bus.rsp_zero), 64'd1);
    push(32'hF0F0_1234, 32'h0FF0_FFFF, F_AND, 4'd6);
    push(32'hAAAA_5555, 32'hFFFF_0000, F_XOR, 4'd7);
    wait_drain();

    // illegal function code
    push(32'd1, 32'd2, 6'b000011, 4'd9);
    chk("ill_strobes", 64'(strobes()), 64'd0);
    @(posedge m_clock); #1;
    chk("ill_flag", 64'(bus.rsp_illegal), 64'd1);
    chk("ill_out", 64'(bus.rsp_out), 64'd0);
    chk("ill_tag", 64'(bus.rsp_tag), 64'd9);
    chk("ill_err", 64'(bus.err_count), 64'd1);
    wait_drain();

    // back-pressure: fill the FIFO behind a held response
    bus.rsp_ready = 1'b0;
    push(32'd10, 32'd1, F_ADD, 4'd1);
    push(32'd20, 32'd2, F_ADD, 4'd2);
    push(32'd30, 32'd3, F_ADD, 4'd3);
    chk("bp_ready", 64'(bus.req_ready), 64'd0);
    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_tag", 64'(bus.rsp_tag), 64'd1);
    repeat (2) @(posedge m_clock);
    #1;
    chk("bp_hold_tag", 64'(bus.rsp_tag), 64'd1);
    chk("bp_hold_out", 64'(bus.rsp_out), 64'd11);
    chk("bp_idle_strobes", 64'(strobes()), 64'd0);
    chk("bp_idle_alu_a", 64'(bus.alu_a), 64'd0);
    bus.rsp_ready = 1'b1;
    @(posedge m_clock); #1;
    chk("bp_tag2", 64'(bus.rsp_tag), 64'd2);
    @(posedge m_clock); #1;
    chk("bp_tag3", 64'(bus.rsp_tag), 64'd3);
    @(posedge m_clock); #1;
    chk("bp_done", 64'(bus.rsp_valid), 64'd0);
    wait_drain();

    // reset with a full FIFO and a pending response
    bus.rsp_ready = 1'b0;
    push(32'd1, 32'd1, F_ADD, 4'd10);
    push(32'd2, 32'd2, F_ADD, 4'd11);
    push(32'd3, 32'd3, F_ADD, 4'd12);
    chk("pre_rst_ready", 64'(bus.req_ready), 64'd0);
    p_reset = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_out", 64'(bus.rsp_out), 64'd0);
    chk("mid_rst_tag", 64'(bus.rsp_tag), 64'd0);
    chk("mid_rst_err", 64'(bus.err_count), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
    @(negedge m_clock); #2;
    p_reset = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge m_clock); #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      @(posedge m_clock); #1;
    end

    // saturation of the illegal request counter
    for (int i = 0; i < 4100; i++) begin
      push(32'(i), 32'(i), 6'b000000, 4'(i));
    end
    wait_drain();
    chk("err_saturate", 64'(bus.err_count), 64'd4095);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/alu32_issue.md
ALU32_ISSUE -- requirements
Module: alu32_issue

Interface
REQ-001 The block SHALL have these ports, one per line (name direction width meaning):
- m_clock  in  1  sole clock; all state updates on its rising edge.
- p_reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
- req_a  in  32  operand a.
- req_b  in  32  operand b.
- req_f  in  6  one-hot function code: 100000 add, 010000 sub, 001000 and, 000100 or, 000010 xor, 000001 nor.
- req_tag  in  4  request identifier, returned with the response.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_op_add, alu_op_sub, alu_op_and, alu_op_or, alu_op_xor, alu_op_nor  out  1 each  ALU operation strobes.
- alu_out  in  32  combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_out  out  32  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_ov  out  1  registered overflow flag.
- rsp_tag  out  4  tag of the request this response belongs to.
- rsp_illegal  out  1  request carried a non-one-hot req_f.
- err_count  out  12  count of illegal requests.

Function
REQ-002 The block SHALL buffer requests in a 2-entry in-order FIFO of {a, b, f, tag}, with occupancy states EMPTY, ONE and FULL.
REQ-003 req_ready SHALL equal (occupancy != FULL); it SHALL NOT depend on rsp_ready, and there is no bypass path.
REQ-004 An exec cycle SHALL occur exactly when the FIFO is non-empty AND (rsp_valid == 0 OR rsp_ready == 1).
REQ-005 In an exec cycle, alu_a and alu_b SHALL carry the FIFO head operands, and exactly the one op strobe matching the head's f SHALL be 1.
REQ-006 Outside exec cycles, all six op strobes, alu_a and alu_b SHALL be 0.
REQ-007 At the end of an exec cycle, the block SHALL:
- load rsp_out/rsp_zero/rsp_ov from alu_out/alu_zero/alu_overflow;
- load rsp_tag from the head tag;
- set rsp_valid to 1 and pop the head.
REQ-008 rsp_valid SHALL clear at an edge where rsp_ready == 1 and no exec occurs; the response register SHALL hold stable while rsp_valid == 1 and rsp_ready == 0.
REQ-009 Latency: a request accepted at edge N with an empty FIFO and an idle response SHALL execute in cycle N..N+1 and show rsp_valid == 1 after edge N+1.
REQ-010 Throughput SHALL be one response per cycle while rsp_ready is held at 1.
REQ-011 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-012 A head whose f is not one-hot SHALL:
- still consume an exec cycle, with no op strobe asserted;
- produce a response with rsp_illegal = 1 and rsp_out = 0, rsp_zero = 0, rsp_ov = 0;
- increment err_count.
For legal requests rsp_illegal SHALL be 0.
REQ-013 err_count SHALL saturate at 4095 (no wrap-around).
REQ-014 The block SHALL pass ALU flags through unmodified, with no recomputation.

Reset
REQ-015 While p_reset is low:
- FIFO SHALL go to EMPTY;
- rsp_valid, rsp_out, rsp_zero, rsp_ov, rsp_tag, rsp_illegal and err_count SHALL be 0;
- all op strobes, alu_a and alu_b SHALL be 0;
- req_ready SHALL be 0.
REQ-016 req_ready SHALL rise at the first rising edge after p_reset deasserts.
REQ-017 Reset asserted mid-operation SHALL discard buffered requests and any pending response, with no partial response emitted afterward.

Verification
REQ-018 The bench SHALL cover these scenarios, with the ALU modelled as a real alu32:
- add 7 + 5, tag 3, rsp_ready = 1 -> alu_op_add pulses one cycle; after edge N+1: rsp_out = 12, zero = 0, ov = 0, tag = 3.
- sub 0x80000000 - 1 -> rsp_out = 0x7FFFFFFF, rsp_ov = 1; then sub 5 - 5 -> rsp_out = 0, rsp_zero = 1.
- req_f = 000011, tag 9 -> no op strobe; rsp_illegal = 1, rsp_out = 0, rsp_tag = 9, err_count = 1.
- rsp_ready = 0, push tags 1, 2, 3 back-to-back -> tag 1 held in response, tags 2 and 3 fill the FIFO, req_ready = 0; raise rsp_ready -> tags 1, 2, 3 emerge on consecutive cycles.
- p_reset low while FIFO is FULL and rsp_valid = 1 -> all outputs 0 immediately; after release, no stale response appears.
- 4100 illegal requests -> err_count = 4095.
